// File: rtl/cpu_io_nibble_bridge.sv
// cpu_io_nibble_bridge
//   CPU-side bridge behind the east-edge CPU I/O tile. A 32-bit two-operand
//   command is framed as one header beat plus eight nibble beats on OPA_O and
//   OPB_O. A 32-bit result is then collected byte-serially from RES0_I and
//   RES1_I, with RES2_I[0] as the byte strobe and RES2_I[2] as the error flag.
//   The result is handed back on a valid/ready response channel. A timeout
//   stops a silent fabric from hanging the CPU.
//
//   Handshake semantics (both channels): a transfer happens on a rising
//   UserCLK edge where valid and ready are both high. The sender holds valid
//   and its payload stable until that edge. The bridge drives cmd_ready only
//   in IDLE. It holds rsp_valid, rsp_data and rsp_err stable in DONE until
//   rsp_ready is sampled high.
//
//   Lane timing: OPA_O/OPB_O are registered decodes of the current state, so
//   the fabric sees each phase one cycle after the state register enters it.
//   wait_live_q marks the cycles in which the fabric can already see WAIT.
//   Only strobes driven during those cycles are admitted, and the timeout
//   counter only runs in those cycles.
module cpu_io_nibble_bridge #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        UserCLK,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_funct,
  input  logic [31:0] cmd_op_a,
  input  logic [31:0] cmd_op_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [3:0]  OPA_O,
  output logic [3:0]  OPB_O,
  input  logic [3:0]  RES0_I,
  input  logic [3:0]  RES1_I,
  input  logic [3:0]  RES2_I,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    SEND = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } state_t;

  // Last legal value of the timeout counter before completion is forced.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  state_t      state_d;

  // Latched command
  logic [3:0]  funct_q;
  logic [31:0] op_a_q;
  logic [31:0] op_b_q;

  // Frame and result progress
  logic [2:0]  beat_q;
  logic [1:0]  byte_cnt_q;
  logic [15:0] to_cnt_q;
  logic        wait_live_q;

  // Result-lane input register stage
  logic [7:0]  res_byte_q;
  logic        res_err_q;
  logic        res_stb_q;

  // Decoded events for the current cycle
  logic        accept;
  logic        wait_act;
  logic        take_byte;
  logic        last_byte;
  logic        timeout_hit;

  // RES2_I[1] and RES2_I[3] carry nothing for this bridge.
  logic        unused_res2;
  assign unused_res2 = ^{RES2_I[3], RES2_I[1]};

  assign dbg_state = state_q;

  // Event decode shared by the FSM and the datapath
  always_comb begin
    accept      = 1'b0;
    wait_act    = 1'b0;
    take_byte   = 1'b0;
    last_byte   = 1'b0;
    timeout_hit = 1'b0;
    accept      = (state_q == IDLE) && cmd_valid && cmd_ready;
    wait_act    = (state_q == WAIT) && wait_live_q;
    take_byte   = wait_act && res_stb_q;
    last_byte   = take_byte && (byte_cnt_q == 2'd3);
    // On a tie, the final byte wins over the timeout.
    timeout_hit = wait_act && !last_byte && (to_cnt_q == TO_LAST);
  end

  // State register
  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = HDR;
        end
      end
      HDR: begin
        state_d = SEND;
      end
      SEND: begin
        if (beat_q == 3'd7) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (last_byte || timeout_hit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Command capture on the accepting edge
  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      funct_q <= 4'h0;
      op_a_q  <= 32'h0;
      op_b_q  <= 32'h0;
    end else if (accept) begin
      funct_q <= cmd_funct;
      op_a_q  <= cmd_op_a;
      op_b_q  <= cmd_op_b;
    end
  end

  // Beat counter; it wraps from 7 back to 0 as SEND ends
  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      beat_q <= 3'd0;
    end else if (state_q == SEND) begin
      beat_q <= beat_q + 3'd1;
    end else begin
      beat_q <= 3'd0;
    end
  end

  // Fabric-facing lanes, decoded from the current state one cycle late
  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      OPA_O <= 4'h0;
      OPB_O <= 4'h0;
    end else begin
      case (state_q)
        HDR: begin
          OPA_O <= 4'hF;
          OPB_O <= funct_q;
        end
        SEND: begin
          OPA_O <= op_a_q[{beat_q, 2'b00} +: 4];
          OPB_O <= op_b_q[{beat_q, 2'b00} +: 4];
        end
        default: begin
          OPA_O <= 4'h0;
          OPB_O <= 4'h0;
        end
      endcase
    end
  end

  // Flags that WAIT is visible to the fabric (one cycle behind the state)
  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      wait_live_q <= 1'b0;
    end else begin
      wait_live_q <= (state_q == WAIT);
    end
  end

  // Result input register; a strobe is admitted only while WAIT is visible
  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      res_byte_q <= 8'h00;
      res_err_q  <= 1'b0;
      res_stb_q  <= 1'b0;
    end else begin
      res_byte_q <= {RES1_I, RES0_I};
      res_err_q  <= RES2_I[2];
      res_stb_q  <= RES2_I[0] && wait_live_q && (state_q == WAIT);
    end
  end

  // Byte and timeout counters, cleared whenever the bridge is outside WAIT
  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      byte_cnt_q <= 2'd0;
      to_cnt_q   <= 16'd0;
    end else if (state_q != WAIT) begin
      byte_cnt_q <= 2'd0;
      to_cnt_q   <= 16'd0;
    end else if (wait_act) begin
      to_cnt_q <= to_cnt_q + 16'd1;
      if (take_byte) begin
        byte_cnt_q <= byte_cnt_q + 2'd1;
      end
    end
  end

  // Result word and error flag: assembled in WAIT, held in DONE, cleared on
  // acceptance
  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      rsp_data <= 32'h0;
      rsp_err  <= 1'b0;
    end else begin
      if (accept) begin
        rsp_data <= 32'h0;
        rsp_err  <= 1'b0;
      end
      if (take_byte) begin
        rsp_data[{byte_cnt_q, 3'b000} +: 8] <= res_byte_q;
        rsp_err                             <= rsp_err | res_err_q;
      end
      if (timeout_hit) begin
        rsp_data <= 32'h0;
        rsp_err  <= 1'b1;
      end
      if ((state_q == DONE) && rsp_ready) begin
        rsp_data <= 32'h0;
        rsp_err  <= 1'b0;
      end
    end
  end

  // Handshake outputs follow the state being entered
  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      cmd_ready <= (state_d == IDLE);
      rsp_valid <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_cpu_io_nibble_bridge.sv
// Bench for cpu_io_nibble_bridge: directed frames from the test plan plus
// randomized frames, with a result model computed from strobe timing.
module tb_cpu_io_nibble_bridge;

  localparam int TO = 16;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_funct;
  logic [31:0] cmd_op_a;
  logic [31:0] cmd_op_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [3:0]  OPA_O;
  logic [3:0]  OPB_O;
  logic [3:0]  RES0_I;
  logic [3:0]  RES1_I;
  logic [3:0]  RES2_I;
  logic [2:0]  dbg_state;

  cpu_io_nibble_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .UserCLK   (clk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_funct (cmd_funct),
    .cmd_op_a  (cmd_op_a),
    .cmd_op_b  (cmd_op_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .OPA_O     (OPA_O),
    .OPB_O     (OPB_O),
    .RES0_I    (RES0_I),
    .RES1_I    (RES1_I),
    .RES2_I    (RES2_I),
    .dbg_state (dbg_state)
  );

  // Scoreboard
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];

  // Fabric response schedule: strobe cycles counted from the first cycle in
  // which the lanes read zero after the last data beat
  int         n_stb;
  int         stb_at[4];
  logic [7:0] stb_byte[4];
  logic       stb_err[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_opa"},       32'(OPA_O),     32'h0);
    chk({tag, "_opb"},       32'(OPB_O),     32'h0);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    chk({tag, "_rsp_data"},  rsp_data,       32'h0);
    chk({tag, "_rsp_err"},   32'(rsp_err),   32'h0);
  endtask

  // Non-strobe lane activity: junk data, strobe low, ignored bits random
  task automatic drive_quiet;
    RES0_I = 4'($urandom);
    RES1_I = 4'($urandom);
    RES2_I = 4'($urandom) & 4'b1110;
  endtask

  task automatic drive_strobe(input logic [7:0] b, input logic e);
    RES0_I = b[3:0];
    RES1_I = b[7:4];
    RES2_I = {1'($urandom), e, 1'($urandom), 1'b1};
  endtask

  task automatic set_sched(input int n, input int t0, input int t1, input int t2,
                           input int t3, input logic [31:0] bytes, input logic [3:0] errs);
    n_stb = n;
    stb_at[0] = t0; stb_at[1] = t1; stb_at[2] = t2; stb_at[3] = t3;
    for (int j = 0; j < 4; j++) begin
      stb_byte[j] = bytes[8*j +: 8];
      stb_err[j]  = errs[j];
    end
  endtask

  // One full command/response transaction.
  task automatic run_frame(input string tag, input logic [3:0] f, input logic [31:0] a,
                           input logic [31:0] b, input int hold, input bit noise);
    logic [31:0] exp_data;
    logic        exp_err;
    logic [7:0]  lanes;
    int          lat;
    int          k;

    // Lane model: header, eight nibble beats LSB first, then quiet
    exp_q.delete();
    exp_q.push_back({4'hF, f});
    for (int i = 0; i < 8; i++) exp_q.push_back({a[4*i +: 4], b[4*i +: 4]});
    exp_q.push_back(8'h00);

    // Result model: a strobe in cycle c lands two edges later; the timeout
    // lands TO edges after the lanes go quiet; the byte wins a tie
    if (n_stb == 4 && stb_at[3] + 2 <= TO) begin
      lat      = stb_at[3] + 2;
      exp_data = {stb_byte[3], stb_byte[2], stb_byte[1], stb_byte[0]};
      exp_err  = stb_err[0] | stb_err[1] | stb_err[2] | stb_err[3];
    end else begin
      lat      = TO;
      exp_data = 32'h0;
      exp_err  = 1'b1;
    end

    k = 0;
    while (!cmd_ready && k < 10) begin
      tick();
      k++;
    end
    chk({tag, "_cmd_ready_idle"}, 32'(cmd_ready), 32'h1);

    // Stray strobes while idle
    if (noise) begin
      repeat ($urandom_range(1, 2)) begin
        drive_strobe(8'($urandom), 1'b1);
        tick();
      end
    end

    cmd_funct = f;
    cmd_op_a  = a;
    cmd_op_b  = b;
    cmd_valid = 1'b1;
    drive_quiet();
    tick();
    // Scramble the command bus so only the latched copy can be used
    cmd_funct = 4'($urandom);
    cmd_op_a  = $urandom;
    cmd_op_b  = $urandom;
    cmd_valid = noise;
    chk({tag, "_cmd_ready_busy"}, 32'(cmd_ready), 32'h0);

    for (int i = 1; i <= 10; i++) begin
      if (noise && (i == 10 || $urandom_range(0, 1) == 1)) drive_strobe(8'($urandom), 1'b1);
      else drive_quiet();
      if (noise) cmd_valid = 1'($urandom);
      tick();
      lanes = exp_q.pop_front();
      chk($sformatf("%s_opa_beat%0d", tag, i), 32'(OPA_O), 32'(lanes[7:4]));
      chk($sformatf("%s_opb_beat%0d", tag, i), 32'(OPB_O), 32'(lanes[3:0]));
      if (noise) chk($sformatf("%s_no_reaccept%0d", tag, i), 32'(cmd_ready), 32'h0);
    end
    cmd_valid = 1'b0;
    rsp_ready = (hold == 0);

    for (int c = 0; c < lat; c++) begin
      drive_quiet();
      for (int j = 0; j < n_stb; j++) begin
        if (stb_at[j] == c) drive_strobe(stb_byte[j], stb_err[j]);
      end
      tick();
      if (c + 1 < lat) begin
        chk($sformatf("%s_valid_low_c%0d", tag, c), 32'(rsp_valid), 32'h0);
      end else begin
        chk({tag, "_valid_rise"}, 32'(rsp_valid), 32'h1);
        chk({tag, "_data"},       rsp_data,       exp_data);
        chk({tag, "_err"},        32'(rsp_err),   32'(exp_err));
      end
    end
    drive_quiet();

    for (int h = 0; h < hold; h++) begin
      tick();
      chk($sformatf("%s_valid_held%0d", tag, h), 32'(rsp_valid), 32'h1);
      chk($sformatf("%s_data_held%0d", tag, h),  rsp_data,       exp_data);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(rsp_valid), 32'h0);
    chk({tag, "_data_clr"},   rsp_data,       32'h0);
    chk({tag, "_err_clr"},    32'(rsp_err),   32'h0);
    chk({tag, "_ready_back"}, 32'(cmd_ready), 32'h1);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          t;
    int          k;

    resetn    = 1'b0;
    cmd_valid = 1'b0;
    cmd_funct = 4'h0;
    cmd_op_a  = 32'h0;
    cmd_op_b  = 32'h0;
    rsp_ready = 1'b0;
    RES0_I    = 4'h0;
    RES1_I    = 4'h0;
    RES2_I    = 4'h0;

    // Reset state
    repeat (3) tick();
    chk_reset_values("reset");
    resetn = 1'b1;
    tick();
    chk("post_reset_ready", 32'(cmd_ready), 32'h1);
    chk("post_reset_opa",   32'(OPA_O),     32'h0);

    // Basic frame and result assembly with gaps 0/3/1, response held 5 cycles
    set_sched(4, 0, 1, 5, 7, 32'hDEAD_BEEF, 4'b0000);
    run_frame("basic", 4'h3, 32'h8765_4321, 32'hFEDC_BA98, 5, 1'b0);

    // Fabric error on byte 1 only; rsp_ready already high
    set_sched(4, 2, 3, 4, 6, 32'h1234_5678, 4'b0010);
    run_frame("fab_err", 4'hA, 32'h0F0F_0F0F, 32'hA5A5_5A5A, 0, 1'b0);

    // Fastest response, back-to-back after the previous zero-hold frame
    set_sched(4, 0, 1, 2, 3, 32'hCAFE_F00D, 4'b0000);
    run_frame("fast_b2b", 4'h0, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1'b0);

    // Two bytes then silence
    set_sched(2, 0, 3, 99, 99, 32'h0000_55AA, 4'b0000);
    run_frame("timeout", 4'h7, 32'h1357_9BDF, 32'h2468_ACE0, 1, 1'b0);

    // Byte 3 on the timeout edge: data wins, no error
    set_sched(4, 0, 1, 2, TO - 2, 32'h0BAD_C0DE, 4'b0000);
    run_frame("tie", 4'h5, 32'h1111_2222, 32'h3333_4444, 1, 1'b0);

    // Byte 3 one cycle too late: timeout wins
    set_sched(4, 0, 1, 2, TO - 1, 32'h7777_7777, 4'b0000);
    run_frame("late", 4'h9, 32'hAAAA_5555, 32'h5555_AAAA, 2, 1'b0);

    // Stray strobes in IDLE/SEND and cmd_valid during SEND
    set_sched(4, 1, 2, 4, 5, 32'h8001_7FFE, 4'b0000);
    run_frame("noise", 4'hC, 32'hC001_D00D, 32'hBEEF_0123, 1, 1'b1);

    // Reset during SEND beat 4
    ra = $urandom;
    rb = $urandom;
    k  = 0;
    while (!cmd_ready && k < 10) begin
      tick();
      k++;
    end
    cmd_funct = 4'h6;
    cmd_op_a  = ra;
    cmd_op_b  = rb;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (6) tick();
    chk("rst_mid_beat4_opa", 32'(OPA_O), 32'(ra[19:16]));
    chk("rst_mid_beat4_opb", 32'(OPB_O), 32'(rb[19:16]));
    resetn = 1'b0;
    drive_strobe(8'h5A, 1'b1);
    tick();
    chk_reset_values("rst_mid");
    resetn = 1'b1;
    drive_quiet();
    tick();
    chk("rst_mid_ready_back", 32'(cmd_ready), 32'h1);
    set_sched(4, 0, 2, 3, 4, 32'h600D_F00D, 4'b0000);
    run_frame("after_rst", 4'h6, ra, rb, 1, 1'b0);

    // Randomized frames
    for (int r = 0; r < 12; r++) begin
      t = $urandom_range(0, 3);
      for (int j = 0; j < 4; j++) begin
        stb_at[j]   = t;
        stb_byte[j] = 8'($urandom);
        stb_err[j]  = ($urandom_range(0, 5) == 0);
        t = t + 1 + $urandom_range(0, 4);
      end
      n_stb = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : 4;
      run_frame($sformatf("rand%0d", r), 4'($urandom), $urandom, $urandom,
                $urandom_range(0, 3), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time limit so a stuck DUT cannot hang the run
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
